bcd_seq_converter: RTL and testbench

//  Multi-cycle binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per clock.

---
 rtl/bcd_seq_converter.sv | 117 +++++++++++
 tb/tb_bcd_seq_converter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
//------------------------------------------------------------------------------
// Module   : bcd_seq_converter
// Brief    : Sequential binary-to-BCD converter (shift-and-add-3), one bit/clk,
//            valid/ready on both sides, one conversion in flight.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_seq_converter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  busy
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam int ACC_W = 4 * DIGITS;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic [WIDTH-1:0]   r_shreg;
   logic [ACC_W-1:0]   r_acc;
   logic [ACC_W-1:0]   r_bcd;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACC_W-1:0]   w_adj;
   logic [ACC_W-1:0]   w_acc_next;
   logic               w_accept;
   logic               w_last;

   // Each digit is corrected independently; a corrected digit never exceeds 12,
   // so no carry can cross into its neighbour.
   for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      assign w_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ? (r_acc[4*g +: 4] + 4'd3)
                                                          : r_acc[4*g +: 4];
   end

   assign w_acc_next = (w_adj << 1) | ACC_W'(r_shreg[WIDTH-1]);
   assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_accept   = (r_state == ST_IDLE) && in_valid;
   assign bcd        = r_bcd;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_next = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // bcd is written only on the final shift so partial sums never show.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shreg <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_bcd   <= '0;
      end else if (w_accept) begin
         r_shreg <= in_data;
         r_acc   <= '0;
         r_cnt   <= '0;
      end else if (r_state == ST_SHIFT) begin
         r_acc   <= w_acc_next;
         r_shreg <= r_shreg << 1;
         r_cnt   <= r_cnt + CNT_W'(1);
         if (w_last) begin
            r_bcd <= w_acc_next;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_seq_converter
// Brief    : Directed bench for bcd_seq_converter with an in-order result queue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bcd_seq_converter;

   localparam int WIDTH  = 8;
   localparam int DIGITS = 3;

   logic                clk;
   logic                rst_n;
   logic                in_valid;
   logic                in_ready;
   logic [WIDTH-1:0]    in_data;
   logic                out_valid;
   logic                out_ready;
   logic [4*DIGITS-1:0] bcd;
   logic                busy;

   int                  n_cmp = 0;
   int                  n_err = 0;
   int                  ready_mode = 1;   // 0: stall, 1: always ready, 2: random
   logic [11:0]         exp_q[$];

   bcd_seq_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd       (bcd),
      .busy      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, required finish before 500us");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [11:0] exp_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Consumer side: out_ready updated shortly after each rising edge.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Result monitor: a handshake at the coming edge retires the oldest entry.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", {20'd0, bcd}, 32'hFFFF_FFFF);
         end else begin
            check("bcd", {20'd0, bcd}, {20'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic send(input int v);
      logic rdy;
      bit   ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      in_data  = v[WIDTH-1:0];
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      if (ok) exp_q.push_back(exp_bcd(v));
      else check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int i = 0; i < 600; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check("drain_left", exp_q.size(), 32'd0);
   endtask

   initial begin
      logic ov [0:WIDTH+1];
      bit   flag;

      rst_n    = 1'b1;
      in_valid = 1'b0;
      in_data  = '0;

      // Asynchronous reset, observed before any clock edge
      #2 rst_n = 1'b0;
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_bcd",       {20'd0, bcd},       32'd0);
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // 255 with latency profile
      ready_mode = 1;
      send(255);
      for (int i = 1; i <= WIDTH + 1; i++) begin
         @(posedge clk);
         #1;
         ov[i] = out_valid;
         if (i == 1) check("busy_in_shift", {31'd0, busy}, 32'd1);
      end
      flag = 1'b0;
      for (int i = 1; i < WIDTH; i++) if (ov[i]) flag = 1'b1;
      check("lat_early_valid", {31'd0, flag},        32'd0);
      check("lat_valid_at_w",  {31'd0, ov[WIDTH]},   32'd1);
      check("lat_valid_drop",  {31'd0, ov[WIDTH+1]}, 32'd0);
      drain();

      // Decimal boundaries, back to back
      send(0);
      send(9);
      send(10);
      send(99);
      send(100);
      send(199);
      drain();

      // Backpressure with a competing operand offered during the hold
      ready_mode = 0;
      @(posedge clk);
      #1;
      send(137);
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         @(posedge clk);
         #1;
      end
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 1'b1;
      in_data  = 8'd42;
      flag     = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (!out_valid || bcd !== 12'h137 || in_ready) flag = 1'b0;
      end
      check("bp_hold", {31'd0, flag}, 32'd1);
      in_valid   = 1'b0;
      ready_mode = 1;
      drain();
      check("bp_idle_ready", {31'd0, in_ready},  32'd1);
      check("bp_no_accept",  {31'd0, busy},      32'd0);

      // Reset in the middle of a conversion
      send(200);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("abort_bcd",       {20'd0, bcd},       32'd0);
      check("abort_out_valid", {31'd0, out_valid}, 32'd0);
      check("abort_in_ready",  {31'd0, in_ready},  32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      flag  = 1'b0;
      for (int i = 0; i < WIDTH + 4; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) flag = 1'b1;
      end
      check("abort_no_result", {31'd0, flag}, 32'd0);
      send(64);
      drain();

      // Every operand, random consumer stalls
      ready_mode = 2;
      for (int v = 0; v < 256; v++) send(v);
      drain();
      ready_mode = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
